// File: rtl/merge2_arbiter.sv
// merge2_arbiter: merges two packet streams onto one output channel using
// round-robin arbitration. Each forwarded packet is preceded by a 1-bit
// winner token on its own channel, so the token always completes first.
// Optional build macro: MERGE2_PKT_COUNT_EN adds per-input 16-bit counters
// (cnt0/cnt1) of packets delivered on the output channel.
module merge2_arbiter #(
  parameter int W       = 9,
  parameter bit RR_INIT = 1'b0
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic         win_data,
  output logic         win_valid,
  input  logic         win_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef MERGE2_PKT_COUNT_EN
  ,
  output logic [15:0]  cnt0,
  output logic [15:0]  cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_W = 2'd1,
    SEND_D = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] pkt_q, pkt_d;
  logic         win_q, win_d;
  logic         prio_q, prio_d;

  logic         grant0, grant1;
  logic         acc0, acc1;

  // Grant: a lone requester wins; on contention the favoured input wins.
  always_comb begin
    grant0 = in0_valid & (~in1_valid | ~prio_q);
    grant1 = in1_valid & (~in0_valid |  prio_q);
  end

  // Readies only in IDLE and never while reset is asserted.
  assign in0_ready = (state_q == IDLE) & grant0 & ~_RESET;
  assign in1_ready = (state_q == IDLE) & grant1 & ~_RESET;
  assign acc0      = in0_valid & in0_ready;
  assign acc1      = in1_valid & in1_ready;

  // Next-state and output decode; outputs are zero outside their phase.
  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    win_d     = win_q;
    prio_d    = prio_q;
    win_valid = 1'b0;
    win_data  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (acc0) begin
          pkt_d   = in0_data;
          win_d   = 1'b0;
          prio_d  = 1'b1;
          state_d = SEND_W;
        end else if (acc1) begin
          pkt_d   = in1_data;
          win_d   = 1'b1;
          prio_d  = 1'b0;
          state_d = SEND_W;
        end
      end
      SEND_W: begin
        win_valid = 1'b1;
        win_data  = win_q;
        if (win_ready) state_d = SEND_D;
      end
      SEND_D: begin
        out_valid = 1'b1;
        out_data  = pkt_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, packet, winner and priority registers.
  always_ff @(posedge CLK) begin
    if (_RESET) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      win_q   <= 1'b0;
      prio_q  <= RR_INIT;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      win_q   <= win_d;
      prio_q  <= prio_d;
    end
  end

`ifdef MERGE2_PKT_COUNT_EN
  logic [15:0] cnt0_q, cnt1_q;

  // Count packets per source when they leave on the output channel.
  always_ff @(posedge CLK) begin
    if (_RESET) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state_q == SEND_D && out_ready) begin
      if (win_q) cnt1_q <= cnt1_q + 16'd1;
      else       cnt0_q <= cnt0_q + 16'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  // No packet counters in this build.
`endif

endmodule

// File: tb/tb_merge2_arbiter.sv
// tb_merge2_arbiter: directed-vector bench for merge2_arbiter.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_merge2_arbiter;

  localparam int W = 9;

  logic         clk;
  logic         rst;
  logic [W-1:0] in0_data, in1_data;
  logic         in0_valid, in1_valid;
  logic         in0_ready, in1_ready;
  logic         win_data, win_valid, win_ready;
  logic [W-1:0] out_data;
  logic         out_valid, out_ready;
`ifdef MERGE2_PKT_COUNT_EN
  logic [15:0]  cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  merge2_arbiter #(.W(W), .RR_INIT(1'b0)) dut (
    .CLK       (clk),
    ._RESET    (rst),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .win_data  (win_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MERGE2_PKT_COUNT_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef MERGE2_PKT_COUNT_EN
  // One full packet from input k with both sinks ready.
  task automatic send_one(input bit k, input logic [W-1:0] d);
    in0_valid = (k == 1'b0);
    in1_valid = (k == 1'b1);
    in0_data  = d;
    in1_data  = d;
    tick();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    tick();
    tick();
    $display("txn cnt src=%0d data=%h", k, d);
  endtask
`endif

  logic [W-1:0] exp_seq [4];

  initial begin
    exp_seq[0] = 9'h011; exp_seq[1] = 9'h122;
    exp_seq[2] = 9'h011; exp_seq[3] = 9'h122;

    rst = 1'b1;
    in0_data = 9'h011; in1_data = 9'h122;
    in0_valid = 1'b1; in1_valid = 1'b1;
    win_ready = 1'b1; out_ready = 1'b1;

    // Reset held two cycles with both valids high.
    tick();
    check("rst_rdy0", {15'd0, in0_ready}, 16'd0);
    check("rst_rdy1", {15'd0, in1_ready}, 16'd0);
    check("rst_wv",   {15'd0, win_valid}, 16'd0);
    check("rst_ov",   {15'd0, out_valid}, 16'd0);
    check("rst_od",   {7'd0, out_data},   16'd0);
    tick();
    check("rst2_rdy0", {15'd0, in0_ready}, 16'd0);
    rst = 1'b0;
    #1;
    check("post_rst_rdy0", {15'd0, in0_ready}, 16'd1);
    check("post_rst_rdy1", {15'd0, in1_ready}, 16'd0);

    // Contention: alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      check("cont_rdy0", {15'd0, in0_ready}, {15'd0, ~i[0]});
      check("cont_rdy1", {15'd0, in1_ready}, {15'd0,  i[0]});
      tick();
      check("cont_wv",  {15'd0, win_valid}, 16'd1);
      check("cont_wd",  {15'd0, win_data},  {15'd0, i[0]});
      check("cont_nordy", {14'd0, in0_ready, in1_ready}, 16'd0);
      tick();
      check("cont_ov", {15'd0, out_valid}, 16'd1);
      check("cont_od", {7'd0, out_data}, {7'd0, exp_seq[i]});
      $display("txn cont pkt=%0d src=%0d data=%h", i, win_data, out_data);
      tick();
    end

    // Single source on input 0.
    in1_valid = 1'b0;
    in0_data  = 9'h1A5;
    #1;
    check("single_rdy0", {15'd0, in0_ready}, 16'd1);
    tick();
    check("single_wv", {15'd0, win_valid}, 16'd1);
    check("single_wd", {15'd0, win_data},  16'd0);
    tick();
    check("single_ov", {15'd0, out_valid}, 16'd1);
    check("single_od", {7'd0, out_data},   16'h01A5);
    $display("txn single data=%h", out_data);
    tick();
    // prio now favours input 1, but input 0 is alone and must win.
    check("single_again_rdy0", {15'd0, in0_ready}, 16'd1);

    // Backpressure: accept 0F0, stall token 5 cycles, then data 3 cycles.
    in0_data = 9'h0F0;
    tick();
    in0_valid = 1'b0;
    in1_valid = 1'b1;
    in1_data  = 9'h155;
    win_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_wv",   {15'd0, win_valid}, 16'd1);
      check("bp_wd",   {15'd0, win_data},  16'd0);
      check("bp_ov",   {15'd0, out_valid}, 16'd0);
      check("bp_nordy", {14'd0, in0_ready, in1_ready}, 16'd0);
      tick();
    end
    win_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ov2", {15'd0, out_valid}, 16'd1);
      check("bp_od2", {7'd0, out_data},   16'h00F0);
      check("bp_nordy2", {14'd0, in0_ready, in1_ready}, 16'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    $display("txn bp data=%h", out_data);
    tick();
    check("bp_done_ov", {15'd0, out_valid}, 16'd0);
    check("bp_next_rdy1", {15'd0, in1_ready}, 16'd1);

    // Reset during SEND_D: accept 0AA from input 0 (prio -> 1), then reset.
    in1_valid = 1'b0;
    in0_valid = 1'b1;
    in0_data  = 9'h0AA;
    tick();
    in0_valid = 1'b0;
    tick();
    check("mid_ov", {15'd0, out_valid}, 16'd1);
    check("mid_od", {7'd0, out_data},   16'h00AA);
    rst = 1'b1;
    tick();
    check("mid_rst_ov", {15'd0, out_valid}, 16'd0);
    check("mid_rst_od", {7'd0, out_data},   16'd0);
    check("mid_rst_wv", {15'd0, win_valid}, 16'd0);
    rst = 1'b0;
    in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = 9'h011; in1_data = 9'h122;
    #1;
    check("mid_prio_rdy0", {15'd0, in0_ready}, 16'd1);
    check("mid_prio_rdy1", {15'd0, in1_ready}, 16'd0);
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    check("mid_wd", {15'd0, win_data}, 16'd0);
    tick();
    check("mid_od2", {7'd0, out_data}, 16'h0011);
    $display("txn mid data=%h", out_data);
    tick();
    check("mid_idle_ov", {15'd0, out_valid}, 16'd0);

`ifdef MERGE2_PKT_COUNT_EN
    // One input-0 packet already delivered since reset.
    send_one(1'b1, 9'h101);
    send_one(1'b1, 9'h102);
    send_one(1'b1, 9'h103);
    send_one(1'b0, 9'h004);
    check("cnt0", cnt0, 16'd2);
    check("cnt1", cnt1, 16'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
